// File: rtl/xy_ctrl_pkg.sv
// Shared constants for the X/Y operand-register write arbiter.
// Holds FSM state encodings, register selectors and requester indices.
package xy_ctrl_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/xy_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: passes requests straight through unless
// they contend, in which case the pointer picks the winner and then flips.
module rr_arb2
    import xy_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       contend,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (contend) begin
                if (ptr == 1'b0) begin
                    grant[REQ_ALU] = 1'b1;
                end else begin
                    grant[REQ_MEM] = 1'b1;
                end
            end else begin
                grant = req;
            end
        end
    end

    // Pointer 0 favours the ALU; it only moves on a contested grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (en && contend) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/xy_write_arbiter.sv
// Arbitrates ALU write-back and memory loads into the X/Y operand registers,
// driving per-register strobes, registered value buses and completion acks.
module xy_write_arbiter
    import xy_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_req,
    input  logic              alu_sel,
    input  logic [DATA_W-1:0] alu_val,
    output logic              alu_ack,
    input  logic              mem_req,
    input  logic              mem_sel,
    input  logic [DATA_W-1:0] mem_val,
    output logic              mem_ack,
    output logic              x_acc_op,
    output logic              x_load,
    output logic              y_acc_op,
    output logic              y_load,
    output logic [DATA_W-1:0] acc_val,
    output logic [DATA_W-1:0] data_val,
    output logic              busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             g_alu;
    logic             g_mem;
    logic             alu_tgt;
    logic             mem_tgt;
    logic [1:0]       req_vec;
    logic [1:0]       grant;
    logic             contend;
    logic             arb_en;
    logic             write_phase;
    logic             ack_phase;

    always_comb begin
        req_vec          = 2'b00;
        req_vec[REQ_ALU] = alu_req;
        req_vec[REQ_MEM] = mem_req;
    end

    // Different targets can be served together; only a shared target contends.
    assign contend = alu_req && mem_req && (alu_sel == mem_sel);
    assign arb_en  = (state == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .contend (contend),
        .req     (req_vec),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            g_alu    <= 1'b0;
            g_mem    <= 1'b0;
            alu_tgt  <= SEL_X;
            mem_tgt  <= SEL_X;
            acc_val  <= '0;
            data_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        state    <= ST_WRITE;
                        hold_cnt <= '0;
                        g_alu    <= grant[REQ_ALU];
                        g_mem    <= grant[REQ_MEM];
                        if (grant[REQ_ALU]) begin
                            alu_tgt <= alu_sel;
                            acc_val <= alu_val;
                        end
                        if (grant[REQ_MEM]) begin
                            mem_tgt  <= mem_sel;
                            data_val <= mem_val;
                        end
                    end
                end
                ST_WRITE: begin
                    if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state <= ST_ACK;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign write_phase = (state == ST_WRITE);
    assign ack_phase   = (state == ST_ACK);
    assign busy        = (state != ST_IDLE);

    assign x_acc_op = write_phase && g_alu && (alu_tgt == SEL_X);
    assign y_acc_op = write_phase && g_alu && (alu_tgt == SEL_Y);
    assign x_load   = write_phase && g_mem && (mem_tgt == SEL_X);
    assign y_load   = write_phase && g_mem && (mem_tgt == SEL_Y);

    assign alu_ack = ack_phase && g_alu;
    assign mem_ack = ack_phase && g_mem;

endmodule

// File: tb/tb_xy_write_arbiter.sv
// Self-checking bench for xy_write_arbiter: a HOLD_CYCLES=1 instance driven from
// a vector table plus a HOLD_CYCLES=3 instance for the mid-write reset case.
module tb_xy_write_arbiter;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          alu_req = 1'b0, alu_sel = 1'b0, mem_req = 1'b0, mem_sel = 1'b0;
    logic [DW-1:0] alu_val = '0, mem_val = '0;
    logic          alu_ack, mem_ack, x_acc_op, x_load, y_acc_op, y_load, busy;
    logic [DW-1:0] acc_val, data_val;

    logic          b_reset = 1'b0;
    logic          b_alu_req = 1'b0, b_alu_sel = 1'b0, b_mem_req = 1'b0, b_mem_sel = 1'b0;
    logic [DW-1:0] b_alu_val = '0, b_mem_val = '0;
    logic          b_alu_ack, b_mem_ack, b_x_acc_op, b_x_load, b_y_acc_op, b_y_load, b_busy;
    logic [DW-1:0] b_acc_val, b_data_val;

    xy_write_arbiter #(.DATA_W(DW), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_sel(alu_sel), .alu_val(alu_val), .alu_ack(alu_ack),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_val(mem_val), .mem_ack(mem_ack),
        .x_acc_op(x_acc_op), .x_load(x_load), .y_acc_op(y_acc_op), .y_load(y_load),
        .acc_val(acc_val), .data_val(data_val), .busy(busy)
    );

    xy_write_arbiter #(.DATA_W(DW), .HOLD_CYCLES(3)) dut_h3 (
        .clk(clk), .reset(b_reset),
        .alu_req(b_alu_req), .alu_sel(b_alu_sel), .alu_val(b_alu_val), .alu_ack(b_alu_ack),
        .mem_req(b_mem_req), .mem_sel(b_mem_sel), .mem_val(b_mem_val), .mem_ack(b_mem_ack),
        .x_acc_op(b_x_acc_op), .x_load(b_x_load), .y_acc_op(b_y_acc_op), .y_load(b_y_load),
        .acc_val(b_acc_val), .data_val(b_data_val), .busy(b_busy)
    );

    typedef struct {
        logic          is_y;
        logic          is_load;
        logic [DW-1:0] val;
    } write_t;

    typedef struct {
        logic          alu_req;
        logic          alu_sel;
        logic [DW-1:0] alu_val;
        logic          mem_req;
        logic          mem_sel;
        logic [DW-1:0] mem_val;
        logic [3:0]    exp_strobe;
        logic [DW-1:0] exp_acc;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_ack;
        logic [DW-1:0] exp_x;
        logic [DW-1:0] exp_y;
    } vec_t;

    write_t        sb_q[$];
    vec_t          vecs[4];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] x_reg = '0;
    logic [DW-1:0] y_reg = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic is_y, input logic is_load, input logic [DW-1:0] val);
        write_t w;
        w.is_y    = is_y;
        w.is_load = is_load;
        w.val     = val;
        sb_q.push_back(w);
    endtask

    task automatic check_write(input logic is_y, input logic is_load, input logic [DW-1:0] val);
        write_t w;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL sb_write: got reg=%0d load=%0d val=%h, expected no write", is_y, is_load, val);
        end else begin
            w = sb_q.pop_front();
            if ({w.is_y, w.is_load, w.val} !== {is_y, is_load, val}) begin
                n_fail++;
                $display("[TB] FAIL sb_write: got reg=%0d load=%0d val=%h, expected reg=%0d load=%0d val=%h",
                         is_y, is_load, val, w.is_y, w.is_load, w.val);
            end
        end
    endtask

    // Observe the HOLD_CYCLES=1 instance: every strobe cycle is one register write.
    always @(negedge clk) begin
        if (reset) begin
            if (x_acc_op) check_write(1'b0, 1'b0, acc_val);
            if (y_acc_op) check_write(1'b1, 1'b0, acc_val);
            if (x_load)   check_write(1'b0, 1'b1, data_val);
            if (y_load)   check_write(1'b1, 1'b1, data_val);
            x_reg <= x_acc_op ? acc_val : (x_load ? data_val : x_reg);
            y_reg <= y_acc_op ? acc_val : (y_load ? data_val : y_reg);
        end
    end

    task automatic apply_stimulus(input vec_t v);
        alu_req = v.alu_req;
        alu_sel = v.alu_sel;
        alu_val = v.alu_val;
        mem_req = v.mem_req;
        mem_sel = v.mem_sel;
        mem_val = v.mem_val;
        if (v.alu_req) push_write(v.alu_sel, 1'b0, v.alu_val);
        if (v.mem_req) push_write(v.mem_sel, 1'b1, v.mem_val);
    endtask

    logic [3:0] c_strobe [3] = '{4'b1000, 4'b0100, 4'b1000};
    logic [1:0] c_ack    [3] = '{2'b10, 2'b01, 2'b10};
    logic [15:0] c_x     [3] = '{16'h0A0A, 16'h0B0B, 16'h0A0A};

    initial begin
        // Strobes are {x_acc_op, x_load, y_acc_op, y_load}; acks are {alu, mem}.
        vecs[0] = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0000,
                    4'b1000, 16'h0002, 16'h0000, 2'b10, 16'h0002, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001,
                    4'b0001, 16'h0002, 16'h0001, 2'b01, 16'h0002, 16'h0001};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h5678,
                    4'b1001, 16'h1234, 16'h5678, 2'b11, 16'h1234, 16'h5678};
        vecs[3] = '{1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0055,
                    4'b0110, 16'h00AA, 16'h0055, 2'b11, 16'h0055, 16'h00AA};

        alu_req = 1'b1; mem_req = 1'b1; alu_val = 16'hFFFF; mem_val = 16'hFFFF;
        b_alu_req = 1'b1; b_mem_req = 1'b1; b_alu_val = 16'hFFFF; b_mem_val = 16'hFFFF;
        repeat (3) step();
        check_output("rst_ctrl_h1", {x_acc_op, x_load, y_acc_op, y_load, alu_ack, mem_ack, busy}, 0);
        check_output("rst_vals_h1", {acc_val, data_val}, 0);
        check_output("rst_ctrl_h3", {b_x_acc_op, b_x_load, b_y_acc_op, b_y_load, b_alu_ack, b_mem_ack, b_busy}, 0);
        check_output("rst_vals_h3", {b_acc_val, b_data_val}, 0);
        alu_req = 1'b0; mem_req = 1'b0; b_alu_req = 1'b0; b_mem_req = 1'b0;
        reset = 1'b1; b_reset = 1'b1;
        step();
        check_output("idle_busy", busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
            step();
            check_output($sformatf("v%0d_strobe", i), {x_acc_op, x_load, y_acc_op, y_load}, vecs[i].exp_strobe);
            check_output($sformatf("v%0d_acc", i), acc_val, vecs[i].exp_acc);
            check_output($sformatf("v%0d_data", i), data_val, vecs[i].exp_data);
            check_output($sformatf("v%0d_ack_early", i), {alu_ack, mem_ack}, 2'b00);
            step();
            check_output($sformatf("v%0d_ack", i), {alu_ack, mem_ack}, vecs[i].exp_ack);
            check_output($sformatf("v%0d_strobe_off", i), {x_acc_op, x_load, y_acc_op, y_load}, 4'b0000);
            check_output($sformatf("v%0d_x", i), x_reg, vecs[i].exp_x);
            check_output($sformatf("v%0d_y", i), y_reg, vecs[i].exp_y);
            alu_req = 1'b0;
            mem_req = 1'b0;
            step();
            check_output($sformatf("v%0d_idle", i), {busy, alu_ack, mem_ack}, 3'b000);
        end

        // Contention on X with both requesters asserting back-to-back.
        alu_req = 1'b1; alu_sel = 1'b0; alu_val = 16'h0A0A;
        mem_req = 1'b1; mem_sel = 1'b0; mem_val = 16'h0B0B;
        push_write(1'b0, 1'b0, 16'h0A0A);
        push_write(1'b0, 1'b1, 16'h0B0B);
        push_write(1'b0, 1'b0, 16'h0A0A);
        for (int t = 0; t < 3; t++) begin
            step();
            check_output($sformatf("rr%0d_strobe", t), {x_acc_op, x_load, y_acc_op, y_load}, c_strobe[t]);
            step();
            check_output($sformatf("rr%0d_ack", t), {alu_ack, mem_ack}, c_ack[t]);
            check_output($sformatf("rr%0d_x", t), x_reg, c_x[t]);
            if (t == 2) begin
                alu_req = 1'b0;
                mem_req = 1'b0;
            end
            step();
            check_output($sformatf("rr%0d_idle", t), busy, 1'b0);
        end

        // Request withdrawn mid-transaction still completes and acks.
        alu_req = 1'b1; alu_sel = 1'b1; alu_val = 16'h0E0E;
        push_write(1'b1, 1'b0, 16'h0E0E);
        step();
        alu_req = 1'b0;
        check_output("drop_strobe", {x_acc_op, x_load, y_acc_op, y_load}, 4'b0010);
        step();
        check_output("drop_ack", {alu_ack, mem_ack}, 2'b10);
        check_output("drop_y", y_reg, 16'h0E0E);
        step();
        check_output("drop_idle", {busy, alu_ack}, 2'b00);

        // Reset in the second strobe cycle of a three-cycle write.
        b_alu_req = 1'b1; b_alu_sel = 1'b1; b_alu_val = 16'h0C0C;
        b_mem_req = 1'b1; b_mem_sel = 1'b0; b_mem_val = 16'h0D0D;
        step();
        check_output("h3_strobe1", {b_x_acc_op, b_x_load, b_y_acc_op, b_y_load}, 4'b0110);
        check_output("h3_vals1", {b_acc_val, b_data_val}, {16'h0C0C, 16'h0D0D});
        step();
        check_output("h3_strobe2", {b_x_acc_op, b_x_load, b_y_acc_op, b_y_load}, 4'b0110);
        #2 b_reset = 1'b0;
        #1;
        check_output("h3_abort", {b_x_acc_op, b_x_load, b_y_acc_op, b_y_load, b_busy}, 5'b0);
        check_output("h3_abort_vals", {b_acc_val, b_data_val}, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            check_output($sformatf("h3_noack%0d", c), {b_alu_ack, b_mem_ack, b_busy}, 3'b000);
        end
        b_reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_output($sformatf("h3_re_strobe%0d", c), {b_x_acc_op, b_x_load, b_y_acc_op, b_y_load},
                         (c < 3) ? 4'b0110 : 4'b0000);
            check_output($sformatf("h3_re_ack%0d", c), {b_alu_ack, b_mem_ack}, (c == 3) ? 2'b11 : 2'b00);
            if (c < 3) check_output($sformatf("h3_re_acc%0d", c), b_acc_val, 16'h0C0C);
            if (c == 3) begin
                b_alu_req = 1'b0;
                b_mem_req = 1'b0;
            end
        end
        check_output("h3_final_busy", b_busy, 1'b0);

        check_output("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
